// File: rtl/mqst_tx_frame.sv
// mqst_tx_frame: Manchester frame transmitter (preamble, sync violation, data words, end marker); optional even parity per word via MQST_TX_PARITY_EN
`timescale 1ns/1ps
module mqst_tx_frame #(
  parameter int DATA_W        = 8,
  parameter int HALF_BIT_CLKS = 4,
  parameter int PREAMBLE_BITS = 8,
  parameter int POLARITY      = 0,
  parameter int MSB_FIRST     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              data_in_last,
  output logic              data_tready,
  output logic              Mqst_BitOut,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              tx_underrun
);
`ifdef MQST_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam logic [15:0] N_PRE  = 16'(2 * PREAMBLE_BITS);
  localparam logic [15:0] N_DATA = 16'(2 * (DATA_W + PAR));
  localparam logic [15:0] T_LAST = 16'(HALF_BIT_CLKS - 1);
  localparam logic        POL    = POLARITY != 0;
  localparam logic        MSB    = MSB_FIRST != 0;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_DATA, S_END} state_t;

  state_t              st;
  logic [15:0]         tmr, hc, n_half;
  logic [DATA_W-1:0]   sh, hold;
  logic                hold_full, hold_last, cur_last, abort;
  logic                hend, last_half, data_bit, lvl;
`ifdef MQST_TX_PARITY_EN
  logic                par;
  // the extra half-bit pair after the data bits carries the word's even parity
  assign data_bit = (hc >= 16'(2 * DATA_W)) ? par : (MSB ? sh[DATA_W-1] : sh[0]);
`else
  assign data_bit = MSB ? sh[DATA_W-1] : sh[0];
`endif

  assign data_tready = !hold_full;
  assign tx_busy     = st != S_IDLE;
  assign hend        = tmr == T_LAST;
  assign n_half      = st == S_PRE ? N_PRE : st == S_SYNC ? 16'd6 : st == S_DATA ? N_DATA : 16'd4;
  assign last_half   = hend && hc == n_half - 16'd1;

  // line level of the current half-bit; first half of a bit is its complement (IEEE), idle is always low
  always_comb begin
    lvl = st == S_IDLE ? 1'b0 :
          st == S_PRE  ? (hc[1] ^ hc[0]) ^ POL :
          st == S_SYNC ? (hc < 16'd3) ^ POL :
          st == S_DATA ? ~(data_bit ^ hc[0]) ^ POL :
          POL;
  end

  // holding register, half-bit timing, frame sequencing and registered line/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      tmr         <= '0;
      hc          <= '0;
      sh          <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      hold_last   <= 1'b0;
      cur_last    <= 1'b0;
      abort       <= 1'b0;
      Mqst_BitOut <= 1'b0;
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
`ifdef MQST_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      Mqst_BitOut <= lvl;
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
      if (data_in_valid && !hold_full) begin
        hold      <= data_in;
        hold_last <= data_in_last;
        hold_full <= 1'b1;
      end
      if (st == S_IDLE) begin
        tmr <= '0;
        hc  <= '0;
        if (hold_full) begin
          st    <= S_PRE;
          abort <= 1'b0;
        end
      end else begin
        tmr <= hend ? '0 : tmr + 16'd1;
        if (hend) hc <= last_half ? '0 : hc + 16'd1;
        if (st == S_DATA && hend && hc[0]) sh <= MSB ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
        if (last_half) begin
          case (st)
            S_PRE:  st <= S_SYNC;
            S_SYNC, S_DATA: begin
              if (st == S_DATA && cur_last) st <= S_END;
              else if (hold_full) begin
                st        <= S_DATA;
                sh        <= hold;
                cur_last  <= hold_last;
                hold_full <= 1'b0;
`ifdef MQST_TX_PARITY_EN
                par       <= ^hold;
`endif
              end else begin
                st          <= S_END;
                tx_underrun <= 1'b1;
                abort       <= 1'b1;
              end
            end
            S_END: begin
              st         <= S_IDLE;
              frame_done <= !abort;
            end
            default: st <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_mqst_tx_frame.sv
// tb_mqst_tx_frame: directed checks of frame waveform, handshake, underrun and mid-frame reset
`timescale 1ns/1ps
module tb_mqst_tx_frame;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [7:0] din = '0;
  logic v0 = 1'b0, v1 = 1'b0, last = 1'b0;
  logic rdy0, bo0, busy0, fd0, ur0, rdy1, bo1, busy1, fd1, ur1;
  int vectors = 0, miscompares = 0, n_done = 0, n_urun = 0, n_done1 = 0, n_urun1 = 0;
  string p0, p1, q;

  always #5 clk = ~clk;

  mqst_tx_frame #(.DATA_W(8), .HALF_BIT_CLKS(2), .PREAMBLE_BITS(4), .POLARITY(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(v0), .data_in_last(last),
    .data_tready(rdy0), .Mqst_BitOut(bo0), .tx_busy(busy0), .frame_done(fd0), .tx_underrun(ur0));

  mqst_tx_frame #(.DATA_W(8), .HALF_BIT_CLKS(2), .PREAMBLE_BITS(4), .POLARITY(1), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(v1), .data_in_last(last),
    .data_tready(rdy1), .Mqst_BitOut(bo1), .tx_busy(busy1), .frame_done(fd1), .tx_underrun(ur1));

  always @(negedge clk) begin
    if (fd0 === 1'b1) n_done++;
    if (ur0 === 1'b1) n_urun++;
    if (fd1 === 1'b1) n_done1++;
    if (ur1 === 1'b1) n_urun1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit sel, input logic [7:0] d, input logic l);
    int t = 0;
    while (!(sel ? rdy1 : rdy0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("tready_wait", t < 400, 1);
    din  = d;
    last = l;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic frame(input bit sel, input string tag, input string exp);
    @(negedge clk);
    for (int c = 0; c < 2 * exp.len(); c++) begin
      @(negedge clk);
      chk($sformatf("%s_half%0d", tag, c / 2), sel ? bo1 : bo0, exp[c/2] == "1");
    end
    @(negedge clk);
    chk({tag, "_idle"}, {sel ? busy1 : busy0, sel ? bo1 : bo0}, 0);
  endtask

  initial begin
`ifdef MQST_TX_PARITY_EN
    p0 = "10"; p1 = "01"; q = "10";
`else
    p0 = ""; p1 = ""; q = "";
`endif
    #1 rst_n = 1'b0;
    #0.1 rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("idle_outputs", {bo0, rdy0, busy0, fd0, ur0}, 5'b01000);
    end
    xfer(0, 8'hA5, 1'b1);
    chk("tready_full", rdy0, 0);
    frame(0, "a5", $sformatf("%s%s%s%s%s", "01100110", "111000", "0110011010011001", p0, "0000"));
    chk("a5_done", n_done, 1);
    chk("a5_urun", n_urun, 0);
    xfer(0, 8'h00, 1'b0);
    fork
      frame(0, "three", $sformatf("%s%s%s%s%s%s%s%s%s", "01100110", "111000", "1010101010101010", p0,
                                  "1010101010101001", p1, "1010101010100110", p1, "0000"));
      begin
        xfer(0, 8'h01, 1'b0);
        xfer(0, 8'h02, 1'b1);
      end
    join
    chk("three_done", n_done, 2);
    chk("three_urun", n_urun, 0);
    xfer(0, 8'h0B, 1'b0);
    frame(0, "under", $sformatf("%s%s%s%s%s", "01100110", "111000", "1010101001100101", p1, "0000"));
    chk("under_urun", n_urun, 1);
    chk("under_done", n_done, 2);
    xfer(0, 8'h33, 1'b1);
    repeat (20) @(negedge clk);
    chk("sync_busy", busy0, 1);
    chk("sync_line", bo0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {bo0, rdy0, busy0, fd0, ur0}, 5'b01000);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_no_pulse", {n_done, n_urun}, {32'd2, 32'd1});
    @(negedge clk);
    xfer(0, 8'h55, 1'b1);
    frame(0, "x55", $sformatf("%s%s%s%s%s", "01100110", "111000", "1001100110011001", p0, "0000"));
    chk("x55_done", n_done, 3);
    xfer(1, 8'h07, 1'b1);
    frame(1, "inv07", $sformatf("%s%s%s%s%s", "10011001", "000111", "1010100101010101", q, "1111"));
    chk("inv07_done", n_done1, 1);
    chk("inv07_urun", n_urun1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
